// File: rtl/stepping_reverse.sv
// stepping_reverse: rewinds Enigma rotor positions one keypress per cycle,
// undoing the forward stepping kernel including the middle-rotor double-step.
//
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   start                     : load request, honoured only in IDLE
//   init_rotor_position_0..2  : slow/middle/fast positions to load
//   rotor_turnover_1/2        : middle/fast turnover notches (stable while busy)
//   num_steps                 : keypresses to undo
//   rotor_position_0..2       : registered slow/middle/fast positions
//   steps_left                : remaining reverse steps
//   busy                      : high while a rewind is in progress
//   done                      : one-cycle pulse when the rewind completes
//   step_err                  : sticky forward-recheck inconsistency flag
//
// Optional feature: define STEPPING_REVERSE_VERIFY_EN to re-run the forward
// kernel on every predecessor and flag any state that does not map back.
// Without it step_err is constant 0.

module stepping_reverse #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [4:0]         init_rotor_position_0,
    input  logic [4:0]         init_rotor_position_1,
    input  logic [4:0]         init_rotor_position_2,
    input  logic [4:0]         rotor_turnover_1,
    input  logic [4:0]         rotor_turnover_2,
    input  logic [COUNT_W-1:0] num_steps,
    output logic [4:0]         rotor_position_0,
    output logic [4:0]         rotor_position_1,
    output logic [4:0]         rotor_position_2,
    output logic [COUNT_W-1:0] steps_left,
    output logic               busy,
    output logic               done,
    output logic               step_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Decrement modulo 26. Out-of-range inputs fold to 25 so the
    // rewind can never produce a position above 25.
    function automatic logic [4:0] dec26(input logic [4:0] x);
        if (x == 5'd0 || x > 5'd25) begin
            return 5'd25;
        end
        return x - 5'd1;
    endfunction

    state_t             state_q, state_d;
    logic [4:0]         pos0_q, pos0_d;
    logic [4:0]         pos1_q, pos1_d;
    logic [4:0]         pos2_q, pos2_d;
    logic [COUNT_W-1:0] steps_q, steps_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Predecessor of the current position triple.
    logic [4:0] prev0, prev1, prev2;
    logic [4:0] q1_dec, p2_dec;

    always_comb begin
        prev2  = dec26(pos2_q);
        q1_dec = dec26(pos1_q);
        p2_dec = dec26(prev2);
        prev1  = pos1_q;
        prev0  = pos0_q;
        if (prev2 == rotor_turnover_2) begin
            // Fast rotor was on its notch: the middle rotor stepped.
            prev1 = q1_dec;
            prev0 = (q1_dec == rotor_turnover_1) ? dec26(pos0_q) : pos0_q;
        end else if (q1_dec == rotor_turnover_1 &&
                     p2_dec == rotor_turnover_2) begin
            // Undo the double-step: middle sat on its own notch one
            // keypress after the fast rotor carried it there.
            prev1 = rotor_turnover_1;
            prev0 = dec26(pos0_q);
        end
    end

`ifdef STEPPING_REVERSE_VERIFY_EN
    function automatic logic [4:0] inc26(input logic [4:0] x);
        return (x >= 5'd25) ? 5'd0 : x + 5'd1;
    endfunction

    logic       err_q, err_d;
    logic [4:0] fwd0, fwd1, fwd2;
    logic       fwd_mismatch;

    // Forward kernel on the predecessor; middle advances one place
    // even when both its own notch and the fast notch are hit.
    always_comb begin
        fwd2 = inc26(prev2);
        fwd1 = prev1;
        fwd0 = prev0;
        if (prev1 == rotor_turnover_1 || prev2 == rotor_turnover_2) begin
            fwd1 = inc26(prev1);
        end
        if (prev1 == rotor_turnover_1) begin
            fwd0 = inc26(prev0);
        end
        fwd_mismatch = ({fwd0, fwd1, fwd2} != {pos0_q, pos1_q, pos2_q});
    end
`endif

    always_comb begin
        state_d = state_q;
        pos0_d  = pos0_q;
        pos1_d  = pos1_q;
        pos2_d  = pos2_q;
        steps_d = steps_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef STEPPING_REVERSE_VERIFY_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pos0_d  = init_rotor_position_0;
                    pos1_d  = init_rotor_position_1;
                    pos2_d  = init_rotor_position_2;
                    steps_d = num_steps;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
`ifdef STEPPING_REVERSE_VERIFY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (steps_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    pos0_d  = prev0;
                    pos1_d  = prev1;
                    pos2_d  = prev2;
                    steps_d = steps_q - 1'b1;
`ifdef STEPPING_REVERSE_VERIFY_EN
                    if (fwd_mismatch) begin
                        err_d = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pos0_q  <= '0;
            pos1_q  <= '0;
            pos2_q  <= '0;
            steps_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef STEPPING_REVERSE_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pos0_q  <= pos0_d;
            pos1_q  <= pos1_d;
            pos2_q  <= pos2_d;
            steps_q <= steps_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef STEPPING_REVERSE_VERIFY_EN
            err_q   <= err_d;
`endif
        end
    end

    assign rotor_position_0 = pos0_q;
    assign rotor_position_1 = pos1_q;
    assign rotor_position_2 = pos2_q;
    assign steps_left       = steps_q;
    assign busy             = busy_q;
    assign done             = done_q;
`ifdef STEPPING_REVERSE_VERIFY_EN
    assign step_err         = err_q;
`else
    assign step_err         = 1'b0;
`endif

endmodule

// File: tb/tb_stepping_reverse.sv
// tb_stepping_reverse: directed checks of the rotor rewind kernel.
// Drives inputs 1ns after posedge and samples 1ns after posedge.

module tb_stepping_reverse;

    localparam int COUNT_W = 16;

    logic               clk;
    logic               reset;
    logic               start;
    logic [4:0]         i0, i1, i2;
    logic [4:0]         t1, t2;
    logic [COUNT_W-1:0] num_steps;
    logic [4:0]         p0, p1, p2;
    logic [COUNT_W-1:0] steps_left;
    logic               busy, done, step_err;

    int checks = 0;
    int errors = 0;

`ifdef STEPPING_REVERSE_VERIFY_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    stepping_reverse #(.COUNT_W(COUNT_W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .init_rotor_position_0 (i0),
        .init_rotor_position_1 (i1),
        .init_rotor_position_2 (i2),
        .rotor_turnover_1      (t1),
        .rotor_turnover_2      (t2),
        .num_steps             (num_steps),
        .rotor_position_0      (p0),
        .rotor_position_1      (p1),
        .rotor_position_2      (p2),
        .steps_left            (steps_left),
        .busy                  (busy),
        .done                  (done),
        .step_err              (step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic [15:0] n);
        i0 = a; i1 = b; i2 = c; num_steps = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({p0, p1, p2, steps_left, busy, done, step_err} !== '0) begin
            errors++;
            $display("FAIL reset_state got %h %h %h sl=%0d b=%b d=%b e=%b want all 0",
                     p0, p1, p2, steps_left, busy, done, step_err);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_double_step();
        logic [14:0] exp [4];
        exp[0] = {5'd1, 5'd5, 5'd23};
        exp[1] = {5'd0, 5'd4, 5'd22};
        exp[2] = {5'd0, 5'd3, 5'd21};
        exp[3] = {5'd0, 5'd3, 5'd20};
        t1 = 5'd4; t2 = 5'd21;
        do_start(5'd1, 5'd5, 5'd23, 16'd3);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({p0, p1, p2} !== exp[k] || steps_left !== 16'(3 - k) ||
                busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL dstep_step%0d got %0d,%0d,%0d sl=%0d b=%b d=%b want %0d,%0d,%0d sl=%0d b=1 d=0",
                         k, p0, p1, p2, steps_left, busy, done,
                         exp[k][14:10], exp[k][9:5], exp[k][4:0], 3 - k);
            end
            if (k < 3) tick();
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || {p0, p1, p2} !== exp[3]) begin
            errors++;
            $display("FAIL dstep_done got d=%b b=%b %0d,%0d,%0d want d=1 b=0 0,3,20",
                     done, busy, p0, p1, p2);
        end
        checks++;
        if (step_err !== 1'b0) begin
            errors++;
            $display("FAIL dstep_err got %b want 0", step_err);
        end
        tick();
        checks++;
        if (done !== 1'b0 || {p0, p1, p2} !== exp[3]) begin
            errors++;
            $display("FAIL dstep_hold got d=%b %0d,%0d,%0d want d=0 0,3,20",
                     done, p0, p1, p2);
        end
    endtask

    task automatic test_full_wrap();
        t1 = 5'd25; t2 = 5'd25;
        do_start(5'd0, 5'd0, 5'd0, 16'd1);
        tick();
        tick();
        checks++;
        if ({p0, p1, p2} !== {5'd25, 5'd25, 5'd25} || done !== 1'b1) begin
            errors++;
            $display("FAIL full_wrap got %0d,%0d,%0d d=%b want 25,25,25 d=1",
                     p0, p1, p2, done);
        end
        checks++;
        if (step_err !== 1'b0) begin
            errors++;
            $display("FAIL full_wrap_err got %b want 0", step_err);
        end
    endtask

    task automatic test_rule_c();
        t1 = 5'd4; t2 = 5'd21;
        do_start(5'd7, 5'd5, 5'd10, 16'd1);
        tick();
        tick();
        checks++;
        if ({p0, p1, p2} !== {5'd7, 5'd5, 5'd9} || done !== 1'b1) begin
            errors++;
            $display("FAIL rule_c got %0d,%0d,%0d d=%b want 7,5,9 d=1",
                     p0, p1, p2, done);
        end
    endtask

    task automatic test_inconsistent();
        t1 = 5'd4; t2 = 5'd21;
        do_start(5'd0, 5'd4, 5'd10, 16'd1);
        tick();
        tick();
        checks++;
        if ({p0, p1, p2} !== {5'd0, 5'd4, 5'd9} || done !== 1'b1) begin
            errors++;
            $display("FAIL incons_pos got %0d,%0d,%0d d=%b want 0,4,9 d=1",
                     p0, p1, p2, done);
        end
        checks++;
        if (step_err !== ERR_EXP) begin
            errors++;
            $display("FAIL incons_err got %b want %b", step_err, ERR_EXP);
        end
        tick();
        checks++;
        if (step_err !== ERR_EXP) begin
            errors++;
            $display("FAIL incons_sticky got %b want %b", step_err, ERR_EXP);
        end
        do_start(5'd3, 5'd3, 5'd3, 16'd0);
        checks++;
        if (step_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_on_start got %b want 0", step_err);
        end
        tick();
    endtask

    task automatic test_zero_steps();
        t1 = 5'd4; t2 = 5'd21;
        do_start(5'd3, 5'd3, 5'd3, 16'd0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || steps_left !== 16'd0) begin
            errors++;
            $display("FAIL zero_busy got b=%b d=%b sl=%0d want b=1 d=0 sl=0",
                     busy, done, steps_left);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || {p0, p1, p2} !== {5'd3, 5'd3, 5'd3}) begin
            errors++;
            $display("FAIL zero_done got d=%b b=%b %0d,%0d,%0d want d=1 b=0 3,3,3",
                     done, busy, p0, p1, p2);
        end
    endtask

    task automatic test_start_while_busy();
        t1 = 5'd4; t2 = 5'd21;
        do_start(5'd3, 5'd3, 5'd3, 16'd2);
        i0 = 5'd9; i1 = 5'd9; i2 = 5'd9; num_steps = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({p0, p1, p2} !== {5'd3, 5'd3, 5'd2} || steps_left !== 16'd1) begin
            errors++;
            $display("FAIL busy_ignore got %0d,%0d,%0d sl=%0d want 3,3,2 sl=1",
                     p0, p1, p2, steps_left);
        end
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || {p0, p1, p2} !== {5'd3, 5'd3, 5'd1}) begin
            errors++;
            $display("FAIL busy_done got d=%b %0d,%0d,%0d want d=1 3,3,1",
                     done, p0, p1, p2);
        end
    endtask

    task automatic test_reset_mid_run();
        t1 = 5'd4; t2 = 5'd21;
        do_start(5'd1, 5'd5, 5'd23, 16'd100);
        repeat (50) tick();
        checks++;
        if (steps_left !== 16'd50 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_count got sl=%0d b=%b want sl=50 b=1",
                     steps_left, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({p0, p1, p2, steps_left, busy, done, step_err} !== '0) begin
            errors++;
            $display("FAIL midrun_reset got %0d,%0d,%0d sl=%0d b=%b d=%b e=%b want all 0",
                     p0, p1, p2, steps_left, busy, done, step_err);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || steps_left !== 16'd0) begin
            errors++;
            $display("FAIL midrun_idle got b=%b d=%b sl=%0d want 0 0 0",
                     busy, done, steps_left);
        end
        t1 = 5'd25; t2 = 5'd25;
        do_start(5'd0, 5'd0, 5'd0, 16'd1);
        tick();
        tick();
        checks++;
        if ({p0, p1, p2} !== {5'd25, 5'd25, 5'd25} || done !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_run got %0d,%0d,%0d d=%b want 25,25,25 d=1",
                     p0, p1, p2, done);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        i0 = '0; i1 = '0; i2 = '0;
        t1 = '0; t2 = '0;
        num_steps = '0;
        test_reset();
        test_double_step();
        test_full_wrap();
        test_rule_c();
        test_inconsistent();
        test_zero_steps();
        test_start_while_busy();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
